// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_IN AXI-stream sources share one registered output.
// Once an input is granted, it keeps the grant until its LAST beat is accepted, so frames never interleave.
module axis_pkt_rr_arbiter #(
  parameter int NUM_IN        = 4,
  parameter int DATA_W        = 64,
  parameter int STALL_TIMEOUT = 1024,
  localparam int KEEP_W       = DATA_W / 8,
  localparam int GRANT_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN*KEEP_W-1:0]   in_keep,
  input  logic [NUM_IN-1:0]          in_last,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [KEEP_W-1:0]          out_keep,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       busy,
  output logic                       err_stall
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic [KEEP_W-1:0]   okeep_q, okeep_d;
  logic                olast_q, olast_d;
  logic                ovalid_q, ovalid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                err_q, err_d;

  logic                load_ok_s;
  logic                accept_s;
  logic                sel_valid_s;
  logic                sel_last_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [KEEP_W-1:0]   sel_keep_s;
  logic [NUM_IN-1:0]   in_ready_s;
  logic                arb_found_s;
  logic [GRANT_W-1:0]  arb_idx_s;
  logic [GRANT_W-1:0]  cand_s;

  // Mux the currently granted input onto the select signals.
  always_comb begin
    sel_valid_s = in_valid[grant_q];
    sel_last_s  = in_last[grant_q];
    sel_data_s  = in_data[grant_q*DATA_W +: DATA_W];
    sel_keep_s  = in_keep[grant_q*KEEP_W +: KEEP_W];
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = grant_q;
    cand_s      = grant_q;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand_s = GRANT_W'((int'(grant_q) + k) % NUM_IN);
      if (!arb_found_s && in_valid[cand_s]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand_s;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Next-state, handshake and output-stage logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    odata_d     = odata_q;
    okeep_d     = okeep_q;
    olast_d     = olast_q;
    ovalid_d    = ovalid_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    in_ready_s  = '0;
    accept_s    = 1'b0;
    load_ok_s   = !ovalid_q || out_ready;

    case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (arb_found_s) begin
          grant_d = arb_idx_s;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        in_ready_s[grant_q] = load_ok_s;
        accept_s            = sel_valid_s && load_ok_s;
        if (accept_s) begin
          stall_cnt_d = '0;
          state_d     = sel_last_s ? ST_IDLE : ST_XFER;
        end else if (!sel_valid_s) begin
          // Counter saturates at the threshold; the error flag is sticky.
          if (stall_cnt_q == CNT_W'(STALL_TIMEOUT - 1)) begin
            err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      odata_d  = sel_data_s;
      okeep_d  = sel_keep_s;
      olast_d  = sel_last_s;
      ovalid_d = 1'b1;
    end else if (out_ready) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_W'(NUM_IN - 1);
      odata_q     <= '0;
      okeep_q     <= '0;
      olast_q     <= 1'b0;
      ovalid_q    <= 1'b0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      odata_q     <= odata_d;
      okeep_q     <= okeep_d;
      olast_q     <= olast_d;
      ovalid_q    <= ovalid_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = odata_q;
  assign out_keep  = okeep_q;
  assign out_last  = olast_q;
  assign out_valid = ovalid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign err_stall = err_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: a cycle table for grant/handshake timing, then
// queue-driven packet sequences checked against hand-ordered expected beat lists.
module tb_axis_pkt_rr_arbiter;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int STALL_TIMEOUT = 1024;

  logic clk = 1'b0;
  logic resetn;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN*KEEP_W-1:0] in_keep;
  logic [NUM_IN-1:0] in_last, in_valid, in_ready;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic out_last, out_valid, out_ready;
  logic [1:0] grant_id;
  logic busy, err_stall;

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .STALL_TIMEOUT(STALL_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
    .busy(busy), .err_stall(err_stall));

  typedef struct packed { logic l; logic [7:0] k; logic [63:0] d; } beat_t;

  typedef struct {
    logic [3:0] v; logic [3:0] l; logic r; logic [7:0] dat;
    logic [3:0] e_ir; logic e_ov; logic e_ol; logic [15:0] e_od; logic [1:0] e_g; logic e_busy;
  } vec_t;

  vec_t  vecs[15];
  beat_t src_q[NUM_IN][$];
  beat_t exp_q[$];
  int    out_cyc_q[$];
  bit    out_lastq[$];
  logic [NUM_IN-1:0] hold;
  int    pop_cnt[NUM_IN];
  int    cyc, beat_cnt, ordy_mode;
  int    checks = 0, errors = 0;
  bit    sb_en, g2_en, prev_hold;
  beat_t prev_b;

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(logic [63:0] base, int b, int n);
    beat_t x;
    x.d = base + 64'(b);
    x.k = 8'hF0 ^ 8'(b) ^ base[15:8];
    x.l = (b == n - 1);
    return x;
  endfunction

  task automatic push_src(int i, int n, logic [63:0] base);
    for (int b = 0; b < n; b++) src_q[i].push_back(mk_beat(base, b, n));
  endtask

  task automatic push_exp(int n, logic [63:0] base);
    for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(base, b, n));
  endtask

  function automatic int src_total();
    int t = 0;
    for (int i = 0; i < NUM_IN; i++) t += src_q[i].size();
    return t;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NUM_IN; i++) begin
      src_q[i].delete();
      pop_cnt[i] = 0;
    end
    exp_q.delete();
    out_cyc_q.delete();
    out_lastq.delete();
    hold = '0;
    beat_cnt = 0;
    prev_hold = 1'b0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        in_valid[i] = 1'b1;
        in_last[i]  = src_q[i][0].l;
        in_data[i*DATA_W +: DATA_W] = src_q[i][0].d;
        in_keep[i*KEEP_W +: KEEP_W] = src_q[i][0].k;
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i*DATA_W +: DATA_W] = 64'h0;
        in_keep[i*KEEP_W +: KEEP_W] = 8'h00;
      end
    end
    out_ready = (ordy_mode == 1) ? ~out_ready : 1'b1;
  endtask

  task automatic monitor();
    beat_t act, e;
    act = {out_last, out_keep, out_data};
    if (prev_hold) chk("hold_stable", {7'b0, out_valid, act}, {7'b0, 1'b1, prev_b});
    if (out_valid && out_ready) begin
      beat_cnt++;
      out_cyc_q.push_back(cyc);
      out_lastq.push_back(out_last);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {7'b0, act}, {7'b0, e});
      end
    end
    if (g2_en && busy) chk("grant_stays_2", {78'b0, grant_id}, 80'd2);
    prev_hold = out_valid && !out_ready;
    prev_b = act;
  endtask

  task automatic step();
    logic [NUM_IN-1:0] acc;
    drive_inputs();
    #1;
    if (sb_en) monitor();
    acc = in_valid & in_ready;
    @(posedge clk);
    for (int i = 0; i < NUM_IN; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        pop_cnt[i]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_total() > 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 80'(exp_q.size() + src_total()), 80'd0);
  endtask

  initial begin
    int n;
    // v, l, out_ready, dat | in_ready, out_valid, out_last, out_data[15:0], grant, busy
    vecs[0]  = '{4'b0100, 4'b0100, 1'b1, 8'h10, 4'b0000, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 8'h11, 4'b0100, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0100, 1'b1, 8'h12, 4'b0000, 1'b1, 1'b1, 16'h1102, 2'd2, 1'b0};
    vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 8'h13, 4'b0100, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1};
    vecs[4]  = '{4'b0101, 4'b0101, 1'b0, 8'h14, 4'b0000, 1'b1, 1'b1, 16'h1302, 2'd2, 1'b0};
    vecs[5]  = '{4'b0101, 4'b0101, 1'b0, 8'h15, 4'b0000, 1'b1, 1'b1, 16'h1302, 2'd0, 1'b1};
    vecs[6]  = '{4'b0101, 4'b0101, 1'b1, 8'h16, 4'b0001, 1'b1, 1'b1, 16'h1302, 2'd0, 1'b1};
    vecs[7]  = '{4'b0101, 4'b0000, 1'b1, 8'h17, 4'b0000, 1'b1, 1'b1, 16'h1600, 2'd0, 1'b0};
    vecs[8]  = '{4'b0101, 4'b0000, 1'b1, 8'h18, 4'b0100, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1};
    vecs[9]  = '{4'b0101, 4'b0100, 1'b1, 8'h19, 4'b0100, 1'b1, 1'b0, 16'h1802, 2'd2, 1'b1};
    vecs[10] = '{4'b0001, 4'b0001, 1'b1, 8'h1A, 4'b0000, 1'b1, 1'b1, 16'h1902, 2'd2, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 8'h1B, 4'b0001, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[12] = '{4'b0001, 4'b0001, 1'b1, 8'h1C, 4'b0001, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[13] = '{4'b0000, 4'b0000, 1'b1, 8'h1D, 4'b0000, 1'b1, 1'b1, 16'h1C00, 2'd0, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 1'b1, 8'h1E, 4'b0000, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};

    cyc = 0; ordy_mode = 0; sb_en = 1'b0; g2_en = 1'b0;
    clear_all();
    resetn = 1'b0; in_valid = '0; in_last = '0; in_data = '0; in_keep = '0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", {79'b0, out_valid}, 80'd0);
    chk("rst_out_last", {79'b0, out_last}, 80'd0);
    chk("rst_out_data", {16'b0, out_data}, 80'd0);
    chk("rst_out_keep", {72'b0, out_keep}, 80'd0);
    chk("rst_in_ready", {76'b0, in_ready}, 80'd0);
    chk("rst_grant", {78'b0, grant_id}, 80'd3);
    chk("rst_busy_err", {78'b0, busy, err_stall}, 80'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Cycle table: grant timing, backpressure, single-beat and two-beat packets
    for (int r = 0; r < 15; r++) begin
      in_valid = vecs[r].v;
      in_last  = vecs[r].l;
      for (int i = 0; i < NUM_IN; i++) begin
        in_data[i*DATA_W +: DATA_W] = {48'h0, vecs[r].dat, 8'(i)};
        in_keep[i*KEEP_W +: KEEP_W] = 8'hFF;
      end
      out_ready = vecs[r].r;
      #1;
      chk($sformatf("vec%0d_in_ready", r), {76'b0, in_ready}, {76'b0, vecs[r].e_ir});
      chk($sformatf("vec%0d_out_valid", r), {79'b0, out_valid}, {79'b0, vecs[r].e_ov});
      chk($sformatf("vec%0d_grant", r), {78'b0, grant_id}, {78'b0, vecs[r].e_g});
      chk($sformatf("vec%0d_busy", r), {79'b0, busy}, {79'b0, vecs[r].e_busy});
      if (vecs[r].e_ov) begin
        chk($sformatf("vec%0d_out_last", r), {79'b0, out_last}, {79'b0, vecs[r].e_ol});
        chk($sformatf("vec%0d_out_data", r), {16'b0, out_data}, {64'b0, vecs[r].e_od});
      end
      @(posedge clk);
      @(negedge clk);
    end

    sb_en = 1'b1;

    // Reset in the middle of a 4-beat packet from input 2
    clear_all();
    push_src(2, 4, 64'hC200);
    push_exp(4, 64'hC200);
    n = 0;
    while (pop_cnt[2] < 2 && n < 50) begin step(); n++; end
    chk("t1_two_beats_in", 80'(pop_cnt[2]), 80'd2);
    #2 resetn = 1'b0;
    #1;
    chk("t1_rst_out_valid", {79'b0, out_valid}, 80'd0);
    chk("t1_rst_in_ready", {76'b0, in_ready}, 80'd0);
    chk("t1_rst_busy", {79'b0, busy}, 80'd0);
    chk("t1_rst_grant", {78'b0, grant_id}, 80'd3);
    clear_all();
    @(negedge clk);
    resetn = 1'b1;
    push_src(0, 2, 64'hD000);
    push_src(3, 2, 64'hD300);
    push_exp(2, 64'hD000);
    push_exp(2, 64'hD300);
    drain("t1_drain", 100);

    // All four inputs, two 3-beat packets each, out_ready held high
    clear_all();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NUM_IN; i++) begin
        push_src(i, 3, 64'hA0 + 64'(i << 8) + 64'(p * 16));
        push_exp(3, 64'hA0 + 64'(i << 8) + 64'(p * 16));
      end
    drain("t2_drain", 200);
    chk("t2_beats", 80'(beat_cnt), 80'd24);
    for (int j = 1; j < out_cyc_q.size(); j++)
      chk($sformatf("t2_gap%0d", j), 80'(out_cyc_q[j] - out_cyc_q[j-1]), out_lastq[j-1] ? 80'd2 : 80'd1);

    // Backpressure: out_ready toggles during a 4-beat packet
    clear_all();
    ordy_mode = 1;
    out_ready = 1'b0;
    push_src(1, 4, 64'hB100);
    push_exp(4, 64'hB100);
    drain("t3_drain", 100);
    ordy_mode = 0;
    repeat (2) step();
    chk("t3_beats", 80'(beat_cnt), 80'd4);

    // Ten single-beat packets from input 2 only
    clear_all();
    g2_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      push_src(2, 1, 64'hE200 + 64'(p * 16));
      push_exp(1, 64'hE200 + 64'(p * 16));
    end
    drain("t4_drain", 100);
    g2_en = 1'b0;
    step();
    chk("t4_beats", 80'(beat_cnt), 80'd10);

    // Stall: input 1 sends one beat then drops VALID; input 3 waits
    clear_all();
    push_src(1, 3, 64'h5100);
    push_exp(3, 64'h5100);
    push_exp(2, 64'h5300);
    n = 0;
    while (pop_cnt[1] < 1 && n < 20) begin step(); n++; end
    chk("t5_first_beat", 80'(pop_cnt[1]), 80'd1);
    hold[1] = 1'b1;
    push_src(3, 2, 64'h5300);
    repeat (STALL_TIMEOUT - 1) step();
    #1;
    chk("t5_err_before", {79'b0, err_stall}, 80'd0);
    step();
    #1;
    chk("t5_err_set", {79'b0, err_stall}, 80'd1);
    chk("t5_grant_held", {78'b0, grant_id}, 80'd1);
    chk("t5_busy", {79'b0, busy}, 80'd1);
    chk("t5_in3_waiting", 80'(pop_cnt[3]), 80'd0);
    hold[1] = 1'b0;
    drain("t5_drain", 100);
    chk("t5_err_sticky", {79'b0, err_stall}, 80'd1);

    // Fairness: input 0 streams, input 3 requests once during input 0's first packet
    clear_all();
    for (int p = 0; p < 4; p++) push_src(0, 2, 64'h6000 + 64'(p * 16));
    step();
    push_src(3, 1, 64'h6300);
    push_exp(2, 64'h6000);
    push_exp(1, 64'h6300);
    for (int p = 1; p < 4; p++) push_exp(2, 64'h6000 + 64'(p * 16));
    drain("t6_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
